wash_seq_param: RTL

- Parametrised washing-machine program sequencer; next generation of the wash controller.
- Takes power, mode and start/pause inputs plus a program select and wash-time preset.
- Drives the fill, drain, wash, rinse and spin actuators and reports remaining total time, remaining phase time and phase code.
- Adds over the previous generation: configurable widths, configurable phase durations and rinse count, a tick prescaler, five programs, pause/resume and saturating time arithmetic.

---
 rtl/wash_seq_param.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/wash_seq_param.sv
// Washing-machine program sequencer: five programs, pause/resume, tick prescaler, saturating time.
// Latency: every output is a flop; a button edge or tick is reflected one clock after it is sampled.
// Backpressure: none; mod/s are edge-detected level buttons, and a pause freezes all timing state.
//
// Ports: ts clock; p async active-low reset; mod program-load button; s start/pause button;
//        Tt1 wash-time preset; mod1 program select; Tt remaining total ticks; Tm remaining phase
//        ticks; li/lo/lw/lr/ld fill/drain/wash/rinse/spin actuators; tp {paused, phase code}.
module wash_seq_param #(
    parameter int TW      = 6,
    parameter int PW      = 5,
    parameter int DIV     = 1,
    parameter int FILL_T  = 2,
    parameter int DRAIN_T = 2,
    parameter int WASH_T  = 6,
    parameter int RINSE_T = 4,
    parameter int SPIN_T  = 3,
    parameter int RINSE_N = 2
) (
    input  logic          ts,
    input  logic          p,
    input  logic          mod,
    input  logic          s,
    input  logic [TW-1:0] Tt1,
    input  logic [2:0]    mod1,
    output logic [TW-1:0] Tt,
    output logic [PW-1:0] Tm,
    output logic          li,
    output logic          lo,
    output logic          lw,
    output logic          lr,
    output logic          ld,
    output logic [3:0]    tp
);
    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_WASH  = 3'd2,
        PH_DRAIN = 3'd3,
        PH_RINSE = 3'd4,
        PH_SPIN  = 3'd5,
        PH_DONE  = 3'd6
    } phase_e;

    localparam int TT_MAX = (1 << TW) - 1;
    localparam int TM_MAX = (1 << PW) - 1;
    localparam int DW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int RW     = (RINSE_N > 1) ? $clog2(RINSE_N) : 1;

    function automatic logic [PW-1:0] phase_dur(input phase_e ph, input logic [PW-1:0] wash);
        logic [PW-1:0] d;
        case (ph)
            PH_FILL:  d = PW'(FILL_T);
            PH_WASH:  d = wash;
            PH_DRAIN: d = PW'(DRAIN_T);
            PH_RINSE: d = PW'(RINSE_T);
            PH_SPIN:  d = PW'(SPIN_T);
            default:  d = '0;
        endcase
        return d;
    endfunction

    // Whole-program duration, computed wide and clamped so long programs never wrap Tt.
    function automatic logic [TW-1:0] prog_total(input logic [2:0] pg, input logic [PW-1:0] wash);
        int wash_blk;
        int rinse_blk;
        int sum;
        wash_blk  = FILL_T + int'(wash) + DRAIN_T;
        rinse_blk = RINSE_N * (FILL_T + RINSE_T + DRAIN_T);
        case (pg)
            3'd1:    sum = wash_blk;
            3'd2:    sum = wash_blk + rinse_blk;
            3'd3:    sum = rinse_blk + SPIN_T;
            3'd4:    sum = DRAIN_T + SPIN_T;
            default: sum = wash_blk + rinse_blk + SPIN_T;
        endcase
        return (sum > TT_MAX) ? TW'(TT_MAX) : TW'(sum);
    endfunction

    function automatic logic [PW-1:0] wash_of(input logic [TW-1:0] t);
        int ti;
        ti = int'(t);
        if (ti == 0)      return PW'(WASH_T);
        if (ti > TM_MAX)  return PW'(TM_MAX);
        return PW'(ti);
    endfunction

    phase_e          phase_q, phase_d, nxt_ph;
    logic            paused_q, paused_d;
    logic [2:0]      prog_q, prog_d;
    logic [PW-1:0]   wash_q, wash_d;
    logic [TW-1:0]   tt_q, tt_d;
    logic [PW-1:0]   tm_q, tm_d;
    logic [DW-1:0]   pre_q, pre_d;
    logic            in_rinse_q, in_rinse_d;   // FILL/DRAIN belong to the rinse block
    logic [RW-1:0]   rcnt_q, rcnt_d;           // rinse cycles already completed
    logic            mod_prev_q, s_prev_q;
    logic            li_q, lo_q, lw_q, lr_q, ld_q;
    logic            li_d, lo_d, lw_d, lr_d, ld_d;
    logic [3:0]      tp_q, tp_d;
    logic            mod_rise, s_rise;

    assign mod_rise = mod & ~mod_prev_q;
    assign s_rise   = s & ~s_prev_q;

    always_comb begin
        phase_d    = phase_q;
        paused_d   = paused_q;
        prog_d     = prog_q;
        wash_d     = wash_q;
        tt_d       = tt_q;
        tm_d       = tm_q;
        pre_d      = pre_q;
        in_rinse_d = in_rinse_q;
        rcnt_d     = rcnt_q;
        nxt_ph     = phase_q;

        case (phase_q)
            PH_IDLE: begin
                paused_d = 1'b0;
                tm_d     = '0;
                tt_d     = prog_total(prog_q, wash_q);
                if (mod_rise) begin
                    prog_d = (mod1 > 3'd4) ? 3'd0 : mod1;
                    wash_d = wash_of(Tt1);
                end
                // Start uses prog_d/wash_d so a same-cycle load is honoured.
                if (s_rise) begin
                    phase_d    = (prog_d == 3'd4) ? PH_DRAIN : PH_FILL;
                    in_rinse_d = (prog_d == 3'd3);
                    rcnt_d     = '0;
                    pre_d      = '0;
                    tm_d       = phase_dur(phase_d, wash_d);
                    tt_d       = prog_total(prog_d, wash_d);
                end
            end
            PH_DONE: begin
                paused_d = 1'b0;
                tt_d     = '0;
                tm_d     = '0;
                if (s_rise || mod_rise) begin
                    phase_d = PH_IDLE;
                    tt_d    = prog_total(prog_q, wash_q);
                end
            end
            default: begin
                if (s_rise) begin
                    paused_d = ~paused_q;
                end else if (!paused_q) begin
                    if (pre_q == DW'(DIV - 1)) begin
                        pre_d = '0;
                        tt_d  = (tt_q == '0) ? '0 : tt_q - 1'b1;
                        if (tm_q == PW'(1)) begin
                            case (phase_q)
                                PH_FILL:  nxt_ph = in_rinse_q ? PH_RINSE : PH_WASH;
                                PH_WASH:  nxt_ph = PH_DRAIN;
                                PH_RINSE: nxt_ph = PH_DRAIN;
                                PH_DRAIN: begin
                                    if (prog_q == 3'd4) begin
                                        nxt_ph = PH_SPIN;
                                    end else if (!in_rinse_q) begin
                                        if (prog_q == 3'd1) begin
                                            nxt_ph = PH_DONE;
                                        end else begin
                                            nxt_ph     = PH_FILL;
                                            in_rinse_d = 1'b1;
                                            rcnt_d     = '0;
                                        end
                                    end else if (rcnt_q == RW'(RINSE_N - 1)) begin
                                        nxt_ph = (prog_q == 3'd2) ? PH_DONE : PH_SPIN;
                                    end else begin
                                        nxt_ph = PH_FILL;
                                        rcnt_d = rcnt_q + 1'b1;
                                    end
                                end
                                default:  nxt_ph = PH_DONE;
                            endcase
                            phase_d = nxt_ph;
                            tm_d    = phase_dur(nxt_ph, wash_q);
                            if (nxt_ph == PH_DONE) tt_d = '0;
                        end else begin
                            tm_d = tm_q - 1'b1;
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
            end
        endcase

        li_d = (phase_d == PH_FILL)  && !paused_d;
        lo_d = (phase_d == PH_DRAIN) && !paused_d;
        lw_d = (phase_d == PH_WASH)  && !paused_d;
        lr_d = (phase_d == PH_RINSE) && !paused_d;
        ld_d = (phase_d == PH_SPIN)  && !paused_d;
        tp_d = {paused_d, phase_d};
    end

    always_ff @(posedge ts or negedge p) begin
        if (!p) begin
            phase_q    <= PH_IDLE;
            paused_q   <= 1'b0;
            prog_q     <= 3'd0;
            wash_q     <= PW'(WASH_T);
            tt_q       <= '0;
            tm_q       <= '0;
            pre_q      <= '0;
            in_rinse_q <= 1'b0;
            rcnt_q     <= '0;
            mod_prev_q <= 1'b0;
            s_prev_q   <= 1'b0;
            li_q       <= 1'b0;
            lo_q       <= 1'b0;
            lw_q       <= 1'b0;
            lr_q       <= 1'b0;
            ld_q       <= 1'b0;
            tp_q       <= '0;
        end else begin
            phase_q    <= phase_d;
            paused_q   <= paused_d;
            prog_q     <= prog_d;
            wash_q     <= wash_d;
            tt_q       <= tt_d;
            tm_q       <= tm_d;
            pre_q      <= pre_d;
            in_rinse_q <= in_rinse_d;
            rcnt_q     <= rcnt_d;
            mod_prev_q <= mod;
            s_prev_q   <= s;
            li_q       <= li_d;
            lo_q       <= lo_d;
            lw_q       <= lw_d;
            lr_q       <= lr_d;
            ld_q       <= ld_d;
            tp_q       <= tp_d;
        end
    end

    assign Tt = tt_q;
    assign Tm = tm_q;
    assign li = li_q;
    assign lo = lo_q;
    assign lw = lw_q;
    assign lr = lr_q;
    assign ld = ld_q;
    assign tp = tp_q;
endmodule
